// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic inter-stage pipeline register with per-lane valid,
//                hold/bubble/advance/flush control, sticky sideband and
//                saturating bubble/hold profiling counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                 DATA_W    = 64,
    parameter int                 LANES     = 1,
    parameter int                 STICKY_W  = 1,
    parameter int                 STAGE     = 2,
    parameter int                 STALL_W   = 6,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [STICKY_W-1:0]       in_sticky,
    input  logic                      cnt_clr,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [STICKY_W-1:0]       out_sticky,
    output logic [CNT_W-1:0]          bubble_cnt,
    output logic [CNT_W-1:0]          hold_cnt,
    output logic                      stall_err
);

    localparam logic [CNT_W-1:0]        C_CNT_MAX  = '1;
    localparam logic [LANES*DATA_W-1:0] C_NOP_ALL  = {LANES{NOP_VALUE}};

    // Stall control decode
    logic w_stall_me;
    logic w_stall_dn;
    logic w_flush;
    logic w_bubble;
    logic w_hold;
    logic w_advance;
    logic w_illegal;

    assign w_stall_me = stall[STAGE];
    assign w_stall_dn = stall[STAGE+1];
    assign w_flush    = flush;
    assign w_bubble   = !flush &&  w_stall_me && !w_stall_dn;
    assign w_hold     = !flush &&  w_stall_me &&  w_stall_dn;
    assign w_advance  = !flush && !w_stall_me;
    assign w_illegal  = !w_stall_me && w_stall_dn;

    // Empty lanes carry NOP_VALUE so downstream never sees stale payload
    logic [LANES*DATA_W-1:0] w_adv_data;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_adv_data[k*DATA_W +: DATA_W] =
            in_valid[k] ? in_data[k*DATA_W +: DATA_W] : NOP_VALUE;
    end

    // Next counter values: clear beats increment, increments saturate
    logic [CNT_W-1:0] w_bubble_next;
    logic [CNT_W-1:0] w_hold_next;

    always_comb begin
        w_bubble_next = bubble_cnt;
        w_hold_next   = hold_cnt;
        if (cnt_clr) begin
            w_bubble_next = '0;
            w_hold_next   = '0;
        end else begin
            if (w_bubble && (bubble_cnt != C_CNT_MAX)) begin
                w_bubble_next = bubble_cnt + CNT_W'(1);
            end
            if (w_hold && (hold_cnt != C_CNT_MAX)) begin
                w_hold_next = hold_cnt + CNT_W'(1);
            end
        end
    end

    // Payload, valid and sideband registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= '0;
            out_data   <= C_NOP_ALL;
            out_sticky <= '0;
        end else if (w_flush) begin
            out_valid  <= '0;
            out_data   <= C_NOP_ALL;
            out_sticky <= '0;
        end else if (w_bubble) begin
            // Sideband survives the bubble (e.g. delay-slot flag)
            out_valid  <= '0;
            out_data   <= C_NOP_ALL;
        end else if (w_advance) begin
            out_valid  <= in_valid;
            out_data   <= w_adv_data;
            out_sticky <= in_sticky;
        end
    end

    // Profiling counters and illegal-stall flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            stall_err  <= 1'b0;
        end else begin
            bubble_cnt <= w_bubble_next;
            hold_cnt   <= w_hold_next;
            if (w_illegal) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
